// File: rtl/md5_msg_loader.sv
// md5_msg_loader: parses SPI command frames into an MD5-padded 512-bit block and a 128-bit target hash.
// Optional mid-frame inactivity abort is compiled in with `define MD5_LOADER_TIMEOUT_EN.
module md5_msg_loader #(
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] CMD_TARGET     = 8'h01,
    parameter logic [7:0] CMD_STRING     = 8'h02,
    parameter logic [7:0] CMD_CLR        = 8'hFF
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         rx_valid,
    input  logic [7:0]   rx_byte,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] msg_block,
    output logic [127:0] target_hash,
    output logic         target_valid,
    output logic         busy,
    output logic [3:0]   err
);
    typedef enum logic [2:0] {IDLE, TGT, LEN, STR, PEND} state_t;
    state_t       state_q, state_d;
    logic [5:0]   idx_q, idx_d;
    logic [5:0]   len_q, len_d;
    logic [127:0] tgt_q, tgt_d;
    logic         tv_q, tv_d;
    logic [511:0] msg_q, msg_d;
    logic         bv_q, bv_d;
    logic [3:0]   err_q, err_d;
`ifdef MD5_LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
`endif
    // next-state, data capture, padding and sticky error logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        tgt_d   = tgt_q;
        tv_d    = tv_q;
        msg_d   = msg_q;
        bv_d    = bv_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (rx_valid) begin
                if (rx_byte == CMD_TARGET) begin
                    state_d = TGT;
                    idx_d   = '0;
                    tv_d    = 1'b0;
                end else if (rx_byte == CMD_STRING) begin
                    state_d = LEN;
                end else if (rx_byte == CMD_CLR) begin
                    err_d = '0;
                end else begin
                    err_d[0] = 1'b1;
                end
            end
            TGT: if (rx_valid) begin
                tgt_d[{idx_q[3:0], 3'b000} +: 8] = rx_byte;
                idx_d = idx_q + 6'd1;
                if (idx_q[3:0] == 4'd15) begin
                    tv_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            LEN: if (rx_valid) begin
                if (rx_byte == 8'd0 || rx_byte > 8'd55) begin
                    err_d[1] = 1'b1;
                    state_d  = IDLE;
                end else begin
                    msg_d   = '0;
                    len_d   = rx_byte[5:0];
                    idx_d   = '0;
                    state_d = STR;
                end
            end
            STR: if (rx_valid) begin
                msg_d[{idx_q, 3'b000} +: 8] = rx_byte;
                idx_d = idx_q + 6'd1;
                if (idx_q == len_q - 6'd1) begin
                    msg_d[{len_q, 3'b000} +: 8] = 8'h80;
                    msg_d[511:448] = {48'd0, 7'd0, len_q, 3'b000};
                    bv_d    = 1'b1;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (rx_valid) err_d[2] = 1'b1;
                if (bv_q && blk_ready) begin
                    bv_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef MD5_LOADER_TIMEOUT_EN
        tmo_d = '0;
        if ((state_q == TGT || state_q == LEN || state_q == STR) && !rx_valid) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                err_d[3] = 1'b1;
                state_d  = IDLE;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
`endif
    end
    // state and datapath registers, cleared by async reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            tgt_q   <= '0;
            tv_q    <= 1'b0;
            msg_q   <= '0;
            bv_q    <= 1'b0;
            err_q   <= '0;
`ifdef MD5_LOADER_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            tgt_q   <= tgt_d;
            tv_q    <= tv_d;
            msg_q   <= msg_d;
            bv_q    <= bv_d;
            err_q   <= err_d;
`ifdef MD5_LOADER_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end
    assign blk_valid    = bv_q;
    assign msg_block    = msg_q;
    assign target_hash  = tgt_q;
    assign target_valid = tv_q;
    assign busy         = state_q != IDLE;
    assign err          = err_q;
endmodule

// File: tb/tb_md5_msg_loader.sv
// tb_md5_msg_loader: table-driven and scoreboard checks of md5_msg_loader (default build, timeout disabled).
module tb_md5_msg_loader;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         rx_valid = 1'b0;
    logic [7:0]   rx_byte = '0;
    logic         blk_ready = 1'b0;
    logic         blk_valid;
    logic [511:0] msg_block;
    logic [127:0] target_hash;
    logic         target_valid;
    logic         busy;
    logic [3:0]   err;
    int           n_vec = 0;
    int           n_bad = 0;
    int           n_pop = 0;
    logic [511:0] sb_q[$];
    logic [511:0] last_blk = '0;

    typedef struct {
        logic [7:0]  op;
        int          nb;
        logic [63:0] b;
        logic [3:0]  exp_err;
        logic        exp_blk;
    } vec_t;
    vec_t vecs[8];

    md5_msg_loader dut (
        .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .msg_block(msg_block),
        .target_hash(target_hash), .target_valid(target_valid), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] pad(input int l, input logic [447:0] raw);
        logic [511:0] r;
        logic [15:0]  bits;
        r = '0;
        for (int i = 0; i < l; i++) r[8*i +: 8] = raw[8*i +: 8];
        r[8*l +: 8] = 8'h80;
        bits = 16'(l * 8);
        r[455:448] = bits[7:0];
        r[463:456] = bits[15:8];
        return r;
    endfunction

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_str(input int l, input logic [447:0] raw);
        send(8'h02);
        send(8'(l));
        last_blk = pad(l, raw);
        sb_q.push_back(last_blk);
        for (int i = 0; i < l; i++) send(raw[8*i +: 8]);
    endtask

    always @(negedge clk) begin
        if (reset_n && blk_valid && blk_ready) begin
            n_pop++;
            if (sb_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_block: got %0h want none", msg_block);
            end else begin
                chk("block", msg_block, sb_q.pop_front());
            end
        end
    end

    initial begin
        logic [447:0] raw;
        int p0;
        vecs[0] = '{8'h02, 4, 64'h0000000063626103, 4'b0000, 1'b1};
        vecs[1] = '{8'h02, 1, 64'h0000000000000000, 4'b0010, 1'b0};
        vecs[2] = '{8'hFF, 0, 64'h0, 4'b0000, 1'b0};
        vecs[3] = '{8'h02, 1, 64'h0000000000000038, 4'b0010, 1'b0};
        vecs[4] = '{8'h7A, 0, 64'h0, 4'b0011, 1'b0};
        vecs[5] = '{8'h02, 3, 64'h000000000001FF02, 4'b0011, 1'b1};
        vecs[6] = '{8'hFF, 0, 64'h0, 4'b0000, 1'b0};
        vecs[7] = '{8'h02, 2, 64'h0000000000007801, 4'b0000, 1'b1};
        idle(2);
        chk("rst_blk_valid", 512'(blk_valid), 512'd0);
        chk("rst_target_valid", 512'(target_valid), 512'd0);
        chk("rst_busy", 512'(busy), 512'd0);
        chk("rst_err", 512'(err), 512'd0);
        chk("rst_msg_block", msg_block, 512'd0);
        chk("rst_target_hash", 512'(target_hash), 512'd0);
        reset_n = 1'b1;
        idle(1);
        send(8'h01);
        chk("tgt_busy", 512'(busy), 512'd1);
        for (int i = 0; i < 16; i++) send(8'(i));
        chk("tgt_valid", 512'(target_valid), 512'd1);
        chk("tgt_hash", 512'(target_hash), 512'(128'h0F0E0D0C0B0A09080706050403020100));
        chk("tgt_err", 512'(err), 512'd0);
        chk("tgt_idle", 512'(busy), 512'd0);
        send(8'h01);
        send(8'hAA);
        chk("tgt_valid_drop", 512'(target_valid), 512'd0);
        for (int i = 1; i < 16; i++) send(8'(i));
        chk("tgt_reload", 512'(target_hash), 512'(128'h0F0E0D0C0B0A090807060504030201AA));
        blk_ready = 1'b1;
        for (int v = 0; v < 8; v++) begin
            raw = '0;
            for (int j = 1; j < vecs[v].nb; j++) raw[8*(j-1) +: 8] = vecs[v].b[8*j +: 8];
            if (vecs[v].exp_blk) begin
                last_blk = pad(int'(vecs[v].b[7:0]), raw);
                sb_q.push_back(last_blk);
            end
            send(vecs[v].op);
            for (int j = 0; j < vecs[v].nb; j++) send(vecs[v].b[8*j +: 8]);
            idle(3);
            chk($sformatf("vec%0d_err", v), 512'(err), 512'(vecs[v].exp_err));
            chk($sformatf("vec%0d_busy", v), 512'(busy), 512'd0);
            chk($sformatf("vec%0d_blk_valid", v), 512'(blk_valid), 512'd0);
            chk($sformatf("vec%0d_msg_block", v), msg_block, last_blk);
            chk($sformatf("vec%0d_sb_empty", v), 512'(sb_q.size()), 512'd0);
        end
        blk_ready = 1'b0;
        raw = '0;
        raw[7:0] = 8'h78;
        send_str(1, raw);
        chk("bp_latency", 512'(blk_valid), 512'd1);
        send(8'h55);
        idle(3);
        chk("bp_hold_valid", 512'(blk_valid), 512'd1);
        chk("bp_stable", msg_block, last_blk);
        chk("bp_err_drop", 512'(err), 512'(4'b0100));
        chk("bp_busy", 512'(busy), 512'd1);
        p0 = n_pop;
        blk_ready = 1'b1;
        idle(1);
        chk("bp_release_valid", 512'(blk_valid), 512'd0);
        chk("bp_release_busy", 512'(busy), 512'd0);
        idle(2);
        chk("bp_one_transfer", 512'(n_pop - p0), 512'd1);
        send(8'hFF);
        blk_ready = 1'b0;
        raw = '0;
        raw[15:0] = 16'h6968;
        send_str(2, raw);
        blk_ready = 1'b1;
        send(8'h33);
        chk("sim_valid", 512'(blk_valid), 512'd0);
        chk("sim_busy", 512'(busy), 512'd0);
        chk("sim_err_drop", 512'(err), 512'(4'b0100));
        send(8'hFF);
        raw = '0;
        for (int i = 0; i < 55; i++) raw[8*i +: 8] = 8'(i * 3 + 1);
        send_str(55, raw);
        idle(3);
        chk("l55_err", 512'(err), 512'd0);
        chk("l55_busy", 512'(busy), 512'd0);
        chk("l55_block", msg_block, last_blk);
        chk("l55_sb_empty", 512'(sb_q.size()), 512'd0);
        send(8'h02);
        send(8'h05);
        send(8'h61);
        send(8'h62);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_blk_valid", 512'(blk_valid), 512'd0);
        chk("arst_msg_block", msg_block, 512'd0);
        chk("arst_target_hash", 512'(target_hash), 512'd0);
        chk("arst_target_valid", 512'(target_valid), 512'd0);
        chk("arst_busy", 512'(busy), 512'd0);
        chk("arst_err", 512'(err), 512'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(2);
        raw = '0;
        raw[23:0] = 24'h7A7978;
        send_str(3, raw);
        idle(3);
        chk("recover_busy", 512'(busy), 512'd0);
        chk("final_sb_empty", 512'(sb_q.size()), 512'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
